// File: rtl/d3s_acq_sequencer.sv
// Acquisition sequencer: writes the ADC stream into a circular RAM with a pre/post trigger window.
// Optional D3S_ACQ_SEQ_SW_TRIG_EN adds a software trigger pulse input ORed with the trig_i edge.
module d3s_acq_sequencer #(
    parameter int g_addr_width = 10,
    parameter int g_data_width = 16
) (
    input  logic                    clk_sys_i,
    input  logic                    rst_n_i,
    input  logic                    start_p_i,
    input  logic                    abort_p_i,
    input  logic [g_addr_width:0]   pre_samples_i,
    input  logic [g_addr_width:0]   post_samples_i,
    input  logic                    trig_i,
`ifdef D3S_ACQ_SEQ_SW_TRIG_EN
    input  logic                    sw_trig_p_i,
`endif
    input  logic [g_data_width-1:0] adc_data_i,
    input  logic                    adc_valid_i,
    output logic                    ram_we_o,
    output logic [g_addr_width-1:0] ram_addr_o,
    output logic [g_data_width-1:0] ram_data_o,
    output logic                    busy_o,
    output logic                    ready_o,
    output logic                    cfg_err_o,
    output logic [g_addr_width-1:0] trig_addr_o,
    output logic [g_addr_width-1:0] start_addr_o
);

    localparam int DEPTH = 2 ** g_addr_width;

    typedef enum logic [2:0] {IDLE, PRE_FILL, WAIT_TRIG, POST, DONE} state_t;

    state_t                  state;
    logic [g_addr_width-1:0] wr_ptr;
    logic [g_addr_width:0]   cnt;
    logic [g_addr_width:0]   pre_r;
    logic [g_addr_width:0]   post_r;
    logic                    trig_d;
    logic                    trig_pend;

    logic                    trig_edge;
    logic                    active;
    logic                    wr_en;
    logic [g_addr_width:0]   post_eff;
    logic [g_addr_width+1:0] win_sum;
    logic                    cfg_bad;
    logic [g_addr_width:0]   cnt_inc;

`ifdef D3S_ACQ_SEQ_SW_TRIG_EN
    assign trig_edge = (trig_i & ~trig_d) | sw_trig_p_i;
`else
    assign trig_edge = trig_i & ~trig_d;
`endif

    assign active   = (state == PRE_FILL) || (state == WAIT_TRIG) || (state == POST);
    assign wr_en    = active & adc_valid_i & ~abort_p_i;
    assign post_eff = (post_samples_i == '0) ? {{g_addr_width{1'b0}}, 1'b1} : post_samples_i;
    assign win_sum  = {1'b0, pre_samples_i} + {1'b0, post_eff};
    assign cfg_bad  = (win_sum > DEPTH[g_addr_width+1:0]);
    assign cnt_inc  = cnt + 1'b1;

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            cnt          <= '0;
            pre_r        <= '0;
            post_r       <= '0;
            trig_d       <= 1'b0;
            trig_pend    <= 1'b0;
            ram_we_o     <= 1'b0;
            ram_addr_o   <= '0;
            ram_data_o   <= '0;
            busy_o       <= 1'b0;
            ready_o      <= 1'b0;
            cfg_err_o    <= 1'b0;
            trig_addr_o  <= '0;
            start_addr_o <= '0;
        end else begin
            trig_d   <= trig_i;
            ram_we_o <= wr_en;
            if (wr_en) begin
                ram_addr_o <= wr_ptr;
                ram_data_o <= adc_data_i;
                wr_ptr     <= wr_ptr + 1'b1;
            end

            if (abort_p_i) begin
                state     <= IDLE;
                busy_o    <= 1'b0;
                ready_o   <= 1'b0;
                trig_pend <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (state == DONE) ready_o <= 1'b1;
                        if (start_p_i) begin
                            if (cfg_bad) begin
                                cfg_err_o <= 1'b1;
                                ready_o   <= 1'b0;
                                state     <= IDLE;
                            end else begin
                                cfg_err_o    <= 1'b0;
                                ready_o      <= 1'b0;
                                busy_o       <= 1'b1;
                                wr_ptr       <= '0;
                                cnt          <= '0;
                                pre_r        <= pre_samples_i;
                                post_r       <= post_eff;
                                trig_pend    <= 1'b0;
                                trig_addr_o  <= '0;
                                start_addr_o <= '0;
                                state        <= PRE_FILL;
                            end
                        end
                    end

                    // Edges seen while the pre-trigger history fills are dropped.
                    PRE_FILL: begin
                        trig_pend <= 1'b0;
                        if (pre_r == '0) begin
                            state <= WAIT_TRIG;
                        end else if (adc_valid_i) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == pre_r) state <= WAIT_TRIG;
                        end
                    end

                    WAIT_TRIG: begin
                        if (adc_valid_i && (trig_pend || trig_edge)) begin
                            trig_addr_o  <= wr_ptr;
                            start_addr_o <= wr_ptr - pre_r[g_addr_width-1:0];
                            cnt          <= {{g_addr_width{1'b0}}, 1'b1};
                            trig_pend    <= 1'b0;
                            if (post_r <= {{g_addr_width{1'b0}}, 1'b1}) begin
                                state  <= DONE;
                                busy_o <= 1'b0;
                            end else begin
                                state <= POST;
                            end
                        end else if (trig_edge) begin
                            trig_pend <= 1'b1;
                        end
                    end

                    POST: begin
                        if (adc_valid_i) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == post_r) begin
                                state  <= DONE;
                                busy_o <= 1'b0;
                            end
                        end
                    end

                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_d3s_acq_sequencer.sv
// Directed bench for d3s_acq_sequencer: window placement, wrap, sparse valid, limits, abort, reset.
module tb_d3s_acq_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_p = 1'b0;
    logic        abort_p = 1'b0;
    logic [10:0] pre = '0;
    logic [10:0] post = '0;
    logic        trig = 1'b0;
    logic        sw_trig = 1'b0;
    logic [15:0] adc_data = '0;
    logic        adc_valid = 1'b0;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [15:0] ram_data;
    logic        busy;
    logic        ready;
    logic        cfg_err;
    logic [9:0]  trig_addr;
    logic [9:0]  start_addr;

    d3s_acq_sequencer #(.g_addr_width(10), .g_data_width(16)) dut (
        .clk_sys_i     (clk),
        .rst_n_i       (rst_n),
        .start_p_i     (start_p),
        .abort_p_i     (abort_p),
        .pre_samples_i (pre),
        .post_samples_i(post),
        .trig_i        (trig),
`ifdef D3S_ACQ_SEQ_SW_TRIG_EN
        .sw_trig_p_i   (sw_trig),
`endif
        .adc_data_i    (adc_data),
        .adc_valid_i   (adc_valid),
        .ram_we_o      (ram_we),
        .ram_addr_o    (ram_addr),
        .ram_data_o    (ram_data),
        .busy_o        (busy),
        .ready_o       (ready),
        .cfg_err_o     (cfg_err),
        .trig_addr_o   (trig_addr),
        .start_addr_o  (start_addr)
    );

    always #8 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          gap_cnt = 0;
    int          last_we_cyc = 0;
    int          ready_rise_cyc = 0;
    logic        wrap_seen = 1'b0;
    logic        prev_we = 1'b0;
    logic        prev_ready = 1'b0;
    logic [9:0]  prev_addr = '0;
    logic [9:0]  last_addr = '0;
    logic [15:0] last_data = '0;
    logic [15:0] mem [0:1023];
    int          base;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM write-port observer, sampled mid-cycle.
    always @(negedge clk) begin
        prev_we    <= ram_we;
        prev_ready <= ready;
        if (ready && !prev_ready) ready_rise_cyc <= cyc;
        if (ram_we) begin
            wr_cnt         <= wr_cnt + 1;
            mem[ram_addr]  <= ram_data;
            last_addr      <= ram_addr;
            last_data      <= ram_data;
            last_we_cyc    <= cyc;
            prev_addr      <= ram_addr;
            if (prev_we && ram_addr != prev_addr + 10'd1) gap_cnt <= gap_cnt + 1;
            if (prev_we && prev_addr == 10'd1023 && ram_addr == 10'd0) wrap_seen <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start_p = 1'b1;
        tick();
        start_p = 1'b0;
    endtask

    task automatic feed(input int n, input int trig_at, input int d0);
        for (int i = 0; i < n; i++) begin
            adc_valid = 1'b1;
            adc_data  = 16'(d0 + i);
            trig      = (i >= trig_at);
            tick();
        end
        adc_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_we", ram_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_trig_addr", trig_addr, 0);
        chk("rst_start_addr", start_addr, 0);
        rst_n = 1'b1;
        tick();

        // Basic window: pre 16, post 32, trigger on sample 40
        pre = 11'd16; post = 11'd32;
        base = wr_cnt;
        do_start();
        chk("basic_busy_rise", busy, 1);
        feed(80, 40, 0);
        chk("basic_trig_addr", trig_addr, 40);
        chk("basic_start_addr", start_addr, 24);
        chk("basic_writes", wr_cnt - base, 72);
        chk("basic_last_addr", last_addr, 71);
        chk("basic_gaps", gap_cnt, 0);
        chk("basic_mem0", mem[0], 0);
        chk("basic_mem40", mem[40], 40);
        chk("basic_ready", ready, 1);
        chk("basic_busy_done", busy, 0);
        chk("basic_ready_lat", ready_rise_cyc - last_we_cyc, 1);

        // Wrap-around: trigger on sample 1030
        pre = 11'd8; post = 11'd8;
        trig = 1'b0;
        base = wr_cnt;
        do_start();
        chk("wrap_ready_clr", ready, 0);
        feed(1050, 1030, 0);
        chk("wrap_trig_addr", trig_addr, 6);
        chk("wrap_start_addr", start_addr, 1022);
        chk("wrap_writes", wr_cnt - base, 1038);
        chk("wrap_seen", wrap_seen, 1);
        chk("wrap_gaps", gap_cnt, 0);
        chk("wrap_mem_trig", mem[6], 1030);
        chk("wrap_ready", ready, 1);

        // Sparse valid, trigger pulse in a non-valid cycle
        pre = 11'd4; post = 11'd4;
        trig = 1'b0;
        base = wr_cnt;
        do_start();
        for (int c = 0; c < 60; c++) begin
            adc_valid = (c % 4 == 0);
            adc_data  = 16'(100 + c / 4);
            trig      = (c == 18);
            tick();
        end
        adc_valid = 1'b0;
        tick();
        chk("sparse_trig_addr", trig_addr, 5);
        chk("sparse_start_addr", start_addr, 1);
        chk("sparse_mem_trig", mem[5], 105);
        chk("sparse_writes", wr_cnt - base, 9);
        chk("sparse_ready", ready, 1);

        // pre = 0, post = 0: single trigger sample then done
        pre = 11'd0; post = 11'd0;
        base = wr_cnt;
        do_start();
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0; adc_valid = 1'b1; adc_data = 16'h0055;
        tick();
        adc_valid = 1'b0;
        tick();
        tick();
        chk("p0_writes", wr_cnt - base, 1);
        chk("p0_last_addr", last_addr, 0);
        chk("p0_last_data", last_data, 16'h0055);
        chk("p0_trig_addr", trig_addr, 0);
        chk("p0_ready", ready, 1);

        // Oversized window is rejected
        pre = 11'd1000; post = 11'd100;
        base = wr_cnt;
        do_start();
        chk("err_cfg", cfg_err, 1);
        chk("err_ready_clr", ready, 0);
        feed(5, 100, 0);
        chk("err_busy", busy, 0);
        chk("err_writes", wr_cnt - base, 0);
        pre = 11'd1024; post = 11'd0;
        do_start();
        chk("err_post0_cfg", cfg_err, 1);
        chk("err_post0_busy", busy, 0);
        pre = 11'd1000; post = 11'd24;
        do_start();
        chk("full_window_cfg", cfg_err, 0);
        chk("full_window_busy", busy, 1);
        abort_p = 1'b1;
        tick();
        abort_p = 1'b0;
        chk("abort_prefill_busy", busy, 0);

        // Abort in POST with a simultaneous start
        pre = 11'd2; post = 11'd20;
        trig = 1'b0;
        do_start();
        for (int i = 0; i < 9; i++) begin
            adc_valid = 1'b1;
            adc_data  = 16'(i);
            trig      = (i >= 5);
            tick();
        end
        chk("abort_pre_busy", busy, 1);
        abort_p = 1'b1; start_p = 1'b1;
        tick();
        abort_p = 1'b0; start_p = 1'b0;
        chk("abort_we", ram_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", ready, 0);
        base = wr_cnt;
        feed(5, 100, 0);
        chk("abort_no_writes", wr_cnt - base, 0);

        // Restart after abort
        pre = 11'd3; post = 11'd5;
        base = wr_cnt;
        do_start();
        feed(15, 6, 200);
        chk("restart_trig_addr", trig_addr, 6);
        chk("restart_start_addr", start_addr, 3);
        chk("restart_writes", wr_cnt - base, 11);
        chk("restart_mem_trig", mem[6], 206);
        chk("restart_ready", ready, 1);

        // Trigger in PRE_FILL is ignored; then reset mid-POST
        pre = 11'd10; post = 11'd50;
        trig = 1'b0;
        do_start();
        for (int i = 0; i <= 20; i++) begin
            adc_valid = 1'b1;
            adc_data  = 16'(300 + i);
            trig      = (i == 3) || (i >= 15);
            tick();
        end
        chk("ign_trig_addr", trig_addr, 15);
        chk("ign_start_addr", start_addr, 5);
        chk("post_we_before_rst", ram_we, 1);
        chk("post_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #2;
        chk("rst_mid_we", ram_we, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_addr", ram_addr, 0);
        chk("rst_mid_data", ram_data, 0);
        chk("rst_mid_trig_addr", trig_addr, 0);
        chk("rst_mid_start_addr", start_addr, 0);
        adc_valid = 1'b0;
        trig = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
